// File: rtl/bfp_frame_normalize.sv
// ============================================================================
//  Module      : bfp_frame_normalize
//  Description : Block-floating-point frame encoder. Buffers one frame, finds
//                the common redundant-sign-bit count and emits the frame
//                left-shifted by it, together with the per-frame exponent.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bfp_frame_normalize #(
  parameter int DATA_WIDTH     = 16,
  parameter int FRAME_LEN_LOG2 = 10,
  parameter int EXP_WIDTH      = 6
) (
  input  logic                    clk_data_out,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [DATA_WIDTH+1:0]   in_real,
  input  logic [DATA_WIDTH+1:0]   in_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [DATA_WIDTH+1:0]   out_real,
  output logic [DATA_WIDTH+1:0]   out_imag,
  output logic [EXP_WIDTH-1:0]    exponent_out,
  output logic                    frame_err
);

  localparam int                   W       = DATA_WIDTH + 2;
  localparam int                   AW      = FRAME_LEN_LOG2;
  localparam int                   N       = 1 << FRAME_LEN_LOG2;
  localparam logic [AW-1:0]        LAST    = AW'(N - 1);
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = EXP_WIDTH'(DATA_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CALC, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_cnt_q, wr_cnt_d;
  logic [AW:0]            rd_cnt_q, rd_cnt_d;
  logic [EXP_WIDTH-1:0]   min_q, min_d, exp_q, exp_d;
  logic                   err_q, err_d;

  logic [2*W-1:0]         mem [N];
  logic [2*W-1:0]         ram_q;
  logic                   wr_en, rd_en;
  logic [AW-1:0]          wr_addr, rd_addr;

  logic                   rd_v_q;
  logic [AW-1:0]          rd_idx_q;
  logic                   o_v_q, o_sop_q, o_eop_q;
  logic [W-1:0]           o_re_q, o_im_q;
  logic                   s_v_q, s_sop_q, s_eop_q;
  logic [W-1:0]           s_re_q, s_im_q;

  logic                   xfer, pop;
  logic [1:0]             occ;
  logic [EXP_WIDTH-1:0]   smp_rs;
  logic [W-1:0]           sh_re, sh_im;
  logic                   rd_sop, rd_eop;

  function automatic logic [EXP_WIDTH-1:0] f_rs(input logic [W-1:0] x);
    logic [EXP_WIDTH-1:0] n;
    logic                 run;
    n   = '0;
    run = 1'b1;
    for (int i = W - 2; i >= 0; i--) begin
      if (run && (x[i] == x[W-1])) n = n + 1'b1;
      else                          run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [EXP_WIDTH-1:0] f_min(input logic [EXP_WIDTH-1:0] a,
                                                 input logic [EXP_WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  assign xfer   = in_valid & in_ready;
  assign pop    = o_v_q & out_ready;
  assign smp_rs = f_min(f_rs(in_real), f_rs(in_imag));
  // Slots still held after this edge; one more read is safe while at most one is taken.
  assign occ    = {1'b0, o_v_q} + {1'b0, s_v_q} + {1'b0, rd_v_q} - {1'b0, pop};
  assign sh_re  = ram_q[2*W-1:W] << exp_q;
  assign sh_im  = ram_q[W-1:0] << exp_q;
  assign rd_sop = (rd_idx_q == '0);
  assign rd_eop = (rd_idx_q == LAST);

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    min_d    = min_q;
    exp_d    = exp_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = wr_cnt_q;
    rd_en    = 1'b0;
    rd_addr  = rd_cnt_q[AW-1:0];
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = reset;
        if (xfer && in_sop) begin
          if (in_eop) begin
            err_d = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_addr  = '0;
            wr_cnt_d = AW'(1);
            min_d    = f_min(EXP_MAX, smp_rs);
            state_d  = S_FILL;
          end
        end
      end
      S_FILL: begin
        in_ready = reset;
        if (xfer) begin
          if (in_sop || (in_eop != (wr_cnt_q == LAST))) begin
            err_d   = 1'b1;
            min_d   = EXP_MAX;
            state_d = S_IDLE;
          end else begin
            wr_en    = 1'b1;
            wr_cnt_d = wr_cnt_q + 1'b1;
            min_d    = f_min(min_q, smp_rs);
            if (wr_cnt_q == LAST) state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        exp_d    = min_q;
        rd_en    = 1'b1;
        rd_addr  = '0;
        rd_cnt_d = (AW+1)'(1);
        state_d  = S_DRAIN;
      end
      default: begin
        if (!rd_cnt_q[AW] && !occ[1]) begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (pop && o_eop_q) begin
          min_d   = EXP_MAX;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_data_out) begin
    if (wr_en) mem[wr_addr] <= {in_real, in_imag};
    if (rd_en) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk_data_out) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      min_q    <= EXP_MAX;
      exp_q    <= '0;
      err_q    <= 1'b0;
      rd_v_q   <= 1'b0;
      rd_idx_q <= '0;
      o_v_q    <= 1'b0;
      o_sop_q  <= 1'b0;
      o_eop_q  <= 1'b0;
      o_re_q   <= '0;
      o_im_q   <= '0;
      s_v_q    <= 1'b0;
      s_sop_q  <= 1'b0;
      s_eop_q  <= 1'b0;
      s_re_q   <= '0;
      s_im_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      min_q    <= min_d;
      exp_q    <= exp_d;
      err_q    <= err_d;
      rd_v_q   <= rd_en;
      rd_idx_q <= rd_addr;
      // Output register advances from the skid first, so order is preserved.
      if (pop || !o_v_q) begin
        if (s_v_q) begin
          o_v_q   <= 1'b1;
          o_sop_q <= s_sop_q;
          o_eop_q <= s_eop_q;
          o_re_q  <= s_re_q;
          o_im_q  <= s_im_q;
          s_v_q   <= rd_v_q;
          if (rd_v_q) begin
            s_sop_q <= rd_sop;
            s_eop_q <= rd_eop;
            s_re_q  <= sh_re;
            s_im_q  <= sh_im;
          end
        end else begin
          o_v_q <= rd_v_q;
          if (rd_v_q) begin
            o_sop_q <= rd_sop;
            o_eop_q <= rd_eop;
            o_re_q  <= sh_re;
            o_im_q  <= sh_im;
          end
        end
      end else if (rd_v_q) begin
        s_v_q   <= 1'b1;
        s_sop_q <= rd_sop;
        s_eop_q <= rd_eop;
        s_re_q  <= sh_re;
        s_im_q  <= sh_im;
      end
    end
  end

  assign out_valid    = o_v_q;
  assign out_sop      = o_sop_q;
  assign out_eop      = o_eop_q;
  assign out_real     = o_re_q;
  assign out_imag     = o_im_q;
  assign exponent_out = exp_q;
  assign frame_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bfp_frame_normalize.sv
// ============================================================================
//  Module      : tb_bfp_frame_normalize
//  Description : Self-checking bench for bfp_frame_normalize (8-sample frames).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bfp_frame_normalize;

  localparam int DW = 16;
  localparam int W  = DW + 2;
  localparam int NF = 8;

  logic          clk_data_out = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_sop, in_eop;
  logic [W-1:0]  in_real, in_imag;
  logic          out_valid, out_ready, out_sop, out_eop;
  logic [W-1:0]  out_real, out_imag;
  logic [5:0]    exponent_out;
  logic          frame_err;

  bfp_frame_normalize #(.DATA_WIDTH(DW), .FRAME_LEN_LOG2(3), .EXP_WIDTH(6)) dut (
    .clk_data_out(clk_data_out), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
    .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .out_real(out_real), .out_imag(out_imag),
    .exponent_out(exponent_out), .frame_err(frame_err)
  );

  always #5 clk_data_out = ~clk_data_out;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [5:0]    ex;
  } rx_t;

  typedef struct packed {
    logic [NF-1:0][W-1:0] re;
    logic [NF-1:0][W-1:0] im;
    logic [5:0]           exp_e;
    logic [2:0]           chk_idx;
    logic [W-1:0]         chk_re;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   eop_cyc = 0;
  bit   want_lat = 0;
  int   mode = 0;
  int   stall_left = 0;
  int   err_pulses = 0;
  int   valid_seen = 0;
  rx_t  rxq[$];
  bit   prev_stall = 0;
  logic [50:0] snap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Largest k such that x * 2**k still fits the signed W-bit range.
  function automatic int rs_model(input logic [W-1:0] x);
    longint v;
    longint p;
    v = longint'($signed(x));
    for (int k = W - 1; k > 0; k--) begin
      p = v * (longint'(1) << k);
      if (p <= 131071 && p >= -131072) return k;
    end
    return 0;
  endfunction

  initial forever begin
    @(posedge clk_data_out);
    cyc++;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk_data_out);
      #1;
      case (mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (rxq.size() == 4 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  initial forever begin
    @(negedge clk_data_out);
    if (reset) begin
      if (prev_stall)
        check("hold_stable", 64'({out_valid, out_sop, out_eop, out_real, out_imag, exponent_out}), 64'(snap));
      if (out_valid && want_lat) begin
        check("latency", 64'(cyc - eop_cyc), 64'd2);
        want_lat = 0;
      end
      if (out_valid && out_ready) rxq.push_back({out_sop, out_eop, out_real, out_imag, exponent_out});
      if (out_valid) valid_seen++;
      if (frame_err) err_pulses++;
      prev_stall = out_valid && !out_ready;
      snap       = {out_valid, out_sop, out_eop, out_real, out_imag, exponent_out};
    end else begin
      prev_stall = 0;
    end
  end

  task automatic send_frame(input logic [NF-1:0][W-1:0] re, input logic [NF-1:0][W-1:0] im,
                            input int n, input int eop_pos, input bit expect_out);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk_data_out);
      #1;
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_eop   = (i == eop_pos);
      in_real  = re[i];
      in_imag  = im[i];
      @(posedge clk_data_out);
      #1;
      if (i == eop_pos && expect_out) begin
        eop_cyc  = cyc;
        want_lat = 1;
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic wait_out();
    int t;
    t = 0;
    while (rxq.size() < NF && t < 300) begin
      @(negedge clk_data_out);
      t++;
    end
    if (rxq.size() < NF) begin
      check("output_timeout", 64'(rxq.size()), 64'(NF));
      while (rxq.size() < NF) rxq.push_back('0);
    end
  endtask

  task automatic check_frame(input logic [NF-1:0][W-1:0] re, input logic [NF-1:0][W-1:0] im);
    int   e;
    rx_t  exp_rx;
    rx_t  got;
    e = W - 1;
    for (int i = 0; i < NF; i++) begin
      if (rs_model(re[i]) < e) e = rs_model(re[i]);
      if (rs_model(im[i]) < e) e = rs_model(im[i]);
    end
    for (int i = 0; i < NF; i++) begin
      exp_rx.sop = (i == 0);
      exp_rx.eop = (i == NF - 1);
      exp_rx.re  = W'(longint'($signed(re[i])) * (longint'(1) << e));
      exp_rx.im  = W'(longint'($signed(im[i])) * (longint'(1) << e));
      exp_rx.ex  = 6'(e);
      got = rxq.pop_front();
      check($sformatf("sample[%0d]", i), 64'(got), 64'(exp_rx));
    end
  endtask

  task automatic gen_rand(output logic [NF-1:0][W-1:0] re, output logic [NF-1:0][W-1:0] im);
    int s;
    s = $urandom_range(0, 17);
    for (int i = 0; i < NF; i++) begin
      re[i] = W'($signed($urandom) >>> (14 + s));
      im[i] = W'($signed($urandom) >>> (14 + s));
    end
  endtask

  vec_t                  vt[4];
  logic [NF-1:0][W-1:0]  fre, fim;
  int                    e0;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_real = '0; in_imag = '0;

    for (int i = 0; i < NF; i++) begin
      vt[0].re[i] = '0;                     vt[0].im[i] = '0;
      vt[1].re[i] = W'(i * 17);             vt[1].im[i] = W'(255 - i * 20);
      vt[2].re[i] = W'(-(i * 30));          vt[2].im[i] = W'(i * 31);
      vt[3].re[i] = W'($urandom_range(0, 4000)); vt[3].im[i] = W'(-i);
    end
    vt[0].exp_e = 6'd17; vt[0].chk_idx = 3'd0; vt[0].chk_re = '0;
    vt[1].re[2] = 18'h00100; vt[1].re[3] = 18'h00001;
    vt[1].exp_e = 6'd8;  vt[1].chk_idx = 3'd2; vt[1].chk_re = 18'h10000;
    vt[2].re[5] = 18'h3FF00;
    vt[2].exp_e = 6'd9;  vt[2].chk_idx = 3'd5; vt[2].chk_re = 18'h20000;
    vt[3].re[0] = 18'h1FFFF;
    vt[3].exp_e = 6'd0;  vt[3].chk_idx = 3'd0; vt[3].chk_re = 18'h1FFFF;

    repeat (3) @(posedge clk_data_out);
    @(negedge clk_data_out);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
    check("rst_data", 64'({out_real, out_imag}), 64'd0);
    check("rst_exponent", 64'(exponent_out), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    @(posedge clk_data_out);
    #1 reset = 1'b1;
    @(negedge clk_data_out);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    for (int v = 0; v < 4; v++) begin
      send_frame(vt[v].re, vt[v].im, NF, NF - 1, 1'b1);
      wait_out();
      check($sformatf("vec%0d_exponent", v), 64'(rxq[0].ex), 64'(vt[v].exp_e));
      check($sformatf("vec%0d_key_sample", v), 64'(rxq[vt[v].chk_idx].re), 64'(vt[v].chk_re));
      check_frame(vt[v].re, vt[v].im);
    end
    repeat (5) @(negedge clk_data_out);
    check("exponent_hold", 64'(exponent_out), 64'd0);

    for (int i = 0; i < NF; i++) begin
      fre[i] = W'(i);
      fim[i] = W'(-i);
    end
    mode = 2; stall_left = 3;
    send_frame(fre, fim, NF, NF - 1, 1'b1);
    wait_out();
    check("stall_count", 64'(stall_left), 64'd0);
    check_frame(fre, fim);
    mode = 0;

    e0 = err_pulses; valid_seen = 0;
    send_frame(vt[1].re, vt[1].im, 5, 4, 1'b0);
    repeat (12) @(negedge clk_data_out);
    check("err_pulse_cycles", 64'(err_pulses - e0), 64'd1);
    check("err_no_output", 64'(valid_seen), 64'd0);
    send_frame(vt[1].re, vt[1].im, NF, NF - 1, 1'b1);
    wait_out();
    check_frame(vt[1].re, vt[1].im);

    mode = 1;
    for (int r = 0; r < 6; r++) begin
      gen_rand(fre, fim);
      send_frame(fre, fim, NF, NF - 1, 1'b1);
      wait_out();
      check_frame(fre, fim);
    end
    mode = 0;

    gen_rand(fre, fim);
    send_frame(fre, fim, NF, NF - 1, 1'b1);
    for (int t = 0; t < 100 && rxq.size() < 2; t++) @(negedge clk_data_out);
    @(posedge clk_data_out);
    #1 reset = 1'b0;
    @(posedge clk_data_out);
    @(negedge clk_data_out);
    check("drain_rst_out_valid", 64'(out_valid), 64'd0);
    check("drain_rst_in_ready", 64'(in_ready), 64'd0);
    check("drain_rst_exponent", 64'(exponent_out), 64'd0);
    @(posedge clk_data_out);
    #1 reset = 1'b1;
    rxq.delete();
    want_lat = 0;
    @(negedge clk_data_out);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    gen_rand(fre, fim);
    send_frame(fre, fim, NF, NF - 1, 1'b1);
    wait_out();
    check_frame(fre, fim);

    repeat (4) @(negedge clk_data_out);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bfp_frame_normalize.md
Name: bfp_frame_normalize

Overview:
Block-floating-point encoder, upstream of the FFT result-alignment stage.
- Buffers one fixed-length frame of complex samples and finds the common count of redundant sign bits across the frame.
- Emits the frame left-shifted by that count, with a per-frame exponent.
- Downstream stages realign two streams by right-shifting the one with the larger exponent by the exponent difference.

Parameters:
data_width, 16, base sample width; I/O samples are data_width+2 bits signed two's complement
frame_len_log2, 10, frame length = 2**frame_len_log2 complex samples
exp_width, 6, exponent width; must hold data_width+1

Ports:
clk_data_out  input  1  single clock, all logic rising-edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  input sample valid
in_ready  output  1  block accepts input; transfer = in_valid & in_ready
in_sop  input  1  first sample of frame
in_eop  input  1  last sample of frame
in_real  input  data_width+2  real part, signed
in_imag  input  data_width+2  imaginary part, signed
out_valid  output  1  output sample valid
out_ready  input  1  downstream accepts; transfer = out_valid & out_ready
out_sop  output  1  first output sample of frame
out_eop  output  1  last output sample of frame
out_real  output  data_width+2  normalized real part
out_imag  output  data_width+2  normalized imaginary part
exponent_out  output  exp_width  frame shift count; constant over the whole output frame
frame_err  output  1  one-cycle pulse on malformed input frame

Behaviour:
- Reset (reset==0 at a clock edge), from any state: state=IDLE, write/read counters=0, running min=data_width+1.
  - Outputs after reset: in_ready=0, out_valid=0, out_sop=0, out_eop=0, out_real=0, out_imag=0, exponent_out=0, frame_err=0.
  - Any partial frame is discarded.
- Storage: single frame RAM, 2**frame_len_log2 x 2(data_width+2) bits, synchronous read with 1-cycle latency.
- FSM states:
  - IDLE: in_ready=1. A transfer with in_sop=1 writes addr 0 and goes to FILL. Transfers without in_sop are dropped silently.
  - FILL: in_ready=1. Each transfer writes the next address.
    - in_eop=1 at addr 2**frame_len_log2-1 -> CALC.
    - in_eop=1 earlier, in_sop=1 mid-frame, or no in_eop at the last addr -> frame_err pulse, back to IDLE, frame discarded.
  - CALC: in_ready=0 for one cycle. Latch exponent_out=running min, reset read counter -> DRAIN.
  - DRAIN: in_ready=0. Stream addr 0..N-1 with out_sop on addr 0 and out_eop on addr N-1. After the out_eop transfer, go to IDLE and set running min=data_width+1.
- Exponent arithmetic:
  - Per sample: rs(x) = (count of leading bits equal to the MSB) - 1, range 0..data_width+1.
  - Running min is taken over rs(in_real) and rs(in_imag) of every accepted sample, including the first.
  - All-zero frame gives exponent data_width+1.
- Output data: out_real = stored_real <<< exponent_out, zeros shifted in. The exponent choice guarantees no overflow and no sign change.
- Output handshake:
  - out_* hold stable while out_valid=1 and out_ready=0.
  - The RAM read-ahead uses a 1-entry skid register so no sample is lost or duplicated.
  - Back-to-back transfers run at 1 sample/cycle while out_ready=1.
- Latency: first out_valid occurs 2 cycles after the in_eop transfer (CALC, then RAM read).
- exponent_out holds its value after DRAIN until the next CALC.

Test Plan:
- Bench config: data_width=16, frame_len_log2=3 (8 samples) for all scenarios.
- All-zero frame -> exponent_out=17; 8 outputs all 0; out_sop on the 1st output, out_eop on the 8th.
- Max-magnitude sample in_real=18'h00100, all other parts in 0..255 -> exponent_out=8; that sample out_real=18'h10000; value 1 -> 18'h00100.
- Frame contains 18'h3FF00 (-256), all others magnitude <=255 -> exponent_out=9; out of -256 = 18'h20000.
- Frame containing 18'h1FFFF -> exponent_out=0; outputs bit-identical to inputs.
- out_ready=0 for 3 cycles at output index 4 -> outputs held stable; sequence 0..7 complete, in order, no duplicates.
- in_eop on the 5th sample -> frame_err=1 for exactly one cycle, no out_valid. Next well-formed frame processes normally.
- reset=0 during DRAIN -> next cycle out_valid=0, in_ready=0. After release, in_ready=1 and the next frame processes normally.
